// File: rtl/match_timer_ctrl.sv
// match_timer_ctrl
//
// Purpose:
//   Match countdown sequencer for time mode. It latches the configured match
//   length and counts it down once per second. The second is measured with an
//   internal clock-enable counter (tick_cnt), not with a divided clock. The
//   block handles start / pause / abort requests from the debounced buttons.
//   It drives the remaining time to the 7-segment display, and the game-enable
//   and time-up signals to the pong game logic.
//
// Ports:
//   clk        in   system clock, all logic on rising edge
//   reset_n    in   asynchronous active-low reset
//   start      in   single-cycle start request
//   pause      in   single-cycle pause/resume toggle
//   abort      in   single-cycle return-to-idle request
//   max_time   in   match length in seconds (TIME_W bits)
//   time_left  out  remaining seconds (TIME_W bits)
//   running    out  high while counting
//   paused     out  high while paused
//   game_en    out  high while counting; gates ball/paddle motion
//   time_up    out  single-cycle pulse when the countdown reaches zero
//   warn       out  running or paused with 0 < time_left <= WARN_SECS
//   blink      out  warn during the first half of each second
//
// All outputs are registered. They are computed from the next-state values,
// so each output lines up exactly with the state register it describes.

`timescale 1ns/1ps

module match_timer_ctrl #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TIME_W    = 8,
    parameter int WARN_SECS = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              pause,
    input  logic              abort,
    input  logic [TIME_W-1:0] max_time,
    output logic [TIME_W-1:0] time_left,
    output logic              running,
    output logic              paused,
    output logic              game_en,
    output logic              time_up,
    output logic              warn,
    output logic              blink
);

    localparam int TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(CLK_HZ - 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CLK_HZ / 2);
    localparam logic [TIME_W-1:0] WARN_LIM  = TIME_W'(WARN_SECS);
    localparam logic [TIME_W-1:0] ONE_SEC   = TIME_W'(1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PAUSE   = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    logic [1:0]        state,    state_nx;
    logic [TICK_W-1:0] tick_cnt, tick_nx;
    logic [TIME_W-1:0] len_q,    len_nx;
    logic [TIME_W-1:0] time_nx;
    logic              up_nx;
    logic              warn_nx;
    logic              blink_nx;

    // Next-state logic. Requests are resolved in the order abort > expiry >
    // pause > start. The expiry-over-pause rule falls out naturally: a
    // pause only moves RUN to PAUSE when the tick did not just expire.
    always_comb begin
        state_nx = state;
        tick_nx  = tick_cnt;
        len_nx   = len_q;
        time_nx  = time_left;
        up_nx    = 1'b0;

        if (abort) begin
            state_nx = ST_IDLE;
            tick_nx  = '0;
            time_nx  = max_time;
        end else begin
            case (state)
                ST_IDLE: begin
                    time_nx = max_time;
                    if (start && (max_time != '0)) begin
                        len_nx   = max_time;
                        tick_nx  = '0;
                        state_nx = ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (tick_cnt == TICK_MAX) begin
                        tick_nx = '0;
                        // A value of 0 cannot be in RUN. Treating it like 1
                        // still guarantees that time_left never underflows.
                        if (time_left <= ONE_SEC) begin
                            time_nx  = '0;
                            state_nx = ST_EXPIRED;
                            up_nx    = 1'b1;
                        end else begin
                            time_nx = time_left - ONE_SEC;
                        end
                    end else begin
                        tick_nx = tick_cnt + TICK_W'(1);
                    end
                    if (pause && (state_nx == ST_RUN)) begin
                        state_nx = ST_PAUSE;
                    end
                end

                ST_PAUSE: begin
                    // tick_cnt is held, so the partial second survives the pause
                    if (pause) begin
                        state_nx = ST_RUN;
                    end
                end

                ST_EXPIRED: begin
                    time_nx = '0;
                    if (start) begin
                        // With no length dialled in, replay the last match length
                        len_nx   = (max_time == '0) ? len_q : max_time;
                        time_nx  = len_nx;
                        tick_nx  = '0;
                        state_nx = ST_RUN;
                    end
                end

                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    // Warning and blink decode, from the same next-state values that are
    // about to be registered
    always_comb begin
        warn_nx  = ((state_nx == ST_RUN) || (state_nx == ST_PAUSE)) &&
                   (time_nx != '0) && (time_nx <= WARN_LIM);
        blink_nx = warn_nx && (tick_nx < TICK_HALF);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            tick_cnt  <= '0;
            len_q     <= '0;
            time_left <= '0;
            running   <= 1'b0;
            paused    <= 1'b0;
            game_en   <= 1'b0;
            time_up   <= 1'b0;
            warn      <= 1'b0;
            blink     <= 1'b0;
        end else begin
            state     <= state_nx;
            tick_cnt  <= tick_nx;
            len_q     <= len_nx;
            time_left <= time_nx;
            running   <= (state_nx == ST_RUN);
            paused    <= (state_nx == ST_PAUSE);
            game_en   <= (state_nx == ST_RUN);
            time_up   <= up_nx;
            warn      <= warn_nx;
            blink     <= blink_nx;
        end
    end

endmodule

// File: tb/tb_match_timer_ctrl.sv
// tb_match_timer_ctrl
//
// Purpose:
//   Self-checking bench for match_timer_ctrl with a one-second period of
//   10 clocks. Every driven cycle pushes the outputs expected from a
//   behavioural reference model into a queue. A monitor pops each entry and
//   compares it one time unit after the clock edge. The scenario tasks also
//   make spot checks against hand-derived values from the match timeline.

`timescale 1ns/1ps

module tb_match_timer_ctrl;

    localparam int CLK_HZ    = 10;
    localparam int TIME_W    = 8;
    localparam int WARN_SECS = 5;

    logic              clk      = 1'b0;
    logic              reset_n  = 1'b0;
    logic              start    = 1'b0;
    logic              pause    = 1'b0;
    logic              abort    = 1'b0;
    logic [TIME_W-1:0] max_time = '0;
    logic [TIME_W-1:0] time_left;
    logic              running;
    logic              paused;
    logic              game_en;
    logic              time_up;
    logic              warn;
    logic              blink;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [TIME_W-1:0] t;
        logic              run;
        logic              pau;
        logic              ge;
        logic              up;
        logic              wrn;
        logic              blk;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Reference model state: 0 idle, 1 run, 2 pause, 3 expired
    int m_st;
    int m_time;
    int m_tick;
    int m_len;
    bit m_up;

    match_timer_ctrl #(
        .CLK_HZ   (CLK_HZ),
        .TIME_W   (TIME_W),
        .WARN_SECS(WARN_SECS)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .pause    (pause),
        .abort    (abort),
        .max_time (max_time),
        .time_left(time_left),
        .running  (running),
        .paused   (paused),
        .game_en  (game_en),
        .time_up  (time_up),
        .warn     (warn),
        .blink    (blink)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_st   = 0;
        m_time = 0;
        m_tick = 0;
        m_len  = 0;
        m_up   = 1'b0;
    endtask

    // One clock of the reference behaviour, using the inputs as currently driven
    task automatic model_step();
        bit wrap;
        m_up = 1'b0;
        if (!reset_n) begin
            model_reset();
        end else if (abort) begin
            m_st   = 0;
            m_tick = 0;
            m_time = int'(max_time);
        end else if (m_st == 0) begin
            m_time = int'(max_time);
            if (start && max_time != 0) begin
                m_len  = int'(max_time);
                m_tick = 0;
                m_st   = 1;
            end
        end else if (m_st == 1) begin
            wrap   = (m_tick == CLK_HZ - 1);
            m_tick = wrap ? 0 : m_tick + 1;
            if (wrap) begin
                if (m_time <= 1) begin
                    m_time = 0;
                    m_st   = 3;
                    m_up   = 1'b1;
                end else begin
                    m_time = m_time - 1;
                end
            end
            if (pause && m_st == 1) m_st = 2;
        end else if (m_st == 2) begin
            if (pause) m_st = 1;
        end else begin
            m_time = 0;
            if (start) begin
                if (max_time != 0) m_len = int'(max_time);
                m_time = m_len;
                m_tick = 0;
                m_st   = 1;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.t   = TIME_W'(m_time);
        e.run = (m_st == 1);
        e.pau = (m_st == 2);
        e.ge  = (m_st == 1);
        e.up  = m_up;
        e.wrn = (m_st == 1 || m_st == 2) && m_time > 0 && m_time <= WARN_SECS;
        e.blk = e.wrn && (m_tick < CLK_HZ / 2);
        return e;
    endfunction

    // Drive one cycle of stimulus at the falling edge and queue its expectation.
    // Return 2 time units after the rising edge, once the monitor has compared.
    task automatic step(input bit s = 1'b0, input bit p = 1'b0, input bit a = 1'b0);
        @(negedge clk);
        start = s;
        pause = p;
        abort = a;
        model_step();
        sb.push_back(model_out());
        @(posedge clk);
        #2;
        start = 1'b0;
        pause = 1'b0;
        abort = 1'b0;
    endtask

    // Scoreboard monitor: compares every queued expectation after its clock edge
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            total++; if (time_left !== mon_e.t)   begin bad++; $display("[TB] FAIL sb_time_left @%0t got=%0d want=%0d", $time, time_left, mon_e.t); end
            total++; if (running   !== mon_e.run) begin bad++; $display("[TB] FAIL sb_running @%0t got=%b want=%b", $time, running, mon_e.run); end
            total++; if (paused    !== mon_e.pau) begin bad++; $display("[TB] FAIL sb_paused @%0t got=%b want=%b", $time, paused, mon_e.pau); end
            total++; if (game_en   !== mon_e.ge)  begin bad++; $display("[TB] FAIL sb_game_en @%0t got=%b want=%b", $time, game_en, mon_e.ge); end
            total++; if (time_up   !== mon_e.up)  begin bad++; $display("[TB] FAIL sb_time_up @%0t got=%b want=%b", $time, time_up, mon_e.up); end
            total++; if (warn      !== mon_e.wrn) begin bad++; $display("[TB] FAIL sb_warn @%0t got=%b want=%b", $time, warn, mon_e.wrn); end
            total++; if (blink     !== mon_e.blk) begin bad++; $display("[TB] FAIL sb_blink @%0t got=%b want=%b", $time, blink, mon_e.blk); end
        end
    end

    task automatic test_reset();
        $display("[TB] test_reset");
        total++; if (time_left !== 8'd0) begin bad++; $display("[TB] FAIL rst_time_left got=%0d want=0", time_left); end
        total++; if ({running, paused, game_en, time_up, warn, blink} !== 6'b0) begin bad++; $display("[TB] FAIL rst_flags got=%b want=000000", {running, paused, game_en, time_up, warn, blink}); end
        reset_n  = 1'b1;
        max_time = 8'd3;
        step();
        total++; if (time_left !== 8'd3) begin bad++; $display("[TB] FAIL idle_follow got=%0d want=3", time_left); end
    endtask

    task automatic test_countdown();
        int ups;
        ups = 0;
        $display("[TB] test_countdown");
        max_time = 8'd3;
        step(1'b1);
        total++; if (running !== 1'b1 || game_en !== 1'b1) begin bad++; $display("[TB] FAIL cd_start got=%b%b want=11", running, game_en); end
        total++; if (time_left !== 8'd3) begin bad++; $display("[TB] FAIL cd_load got=%0d want=3", time_left); end
        for (int i = 1; i <= 30; i++) begin
            step();
            if (time_up) ups++;
            if (i == 10) begin total++; if (time_left !== 8'd2) begin bad++; $display("[TB] FAIL cd_sec1 got=%0d want=2", time_left); end end
            if (i == 20) begin total++; if (time_left !== 8'd1) begin bad++; $display("[TB] FAIL cd_sec2 got=%0d want=1", time_left); end end
            if (i == 29) begin total++; if (time_left !== 8'd1) begin bad++; $display("[TB] FAIL cd_pre_exp got=%0d want=1", time_left); end end
            if (i == 30) begin
                total++; if (time_left !== 8'd0 || time_up !== 1'b1) begin bad++; $display("[TB] FAIL cd_expire got=%0d/%b want=0/1", time_left, time_up); end
                total++; if (running !== 1'b0 || game_en !== 1'b0) begin bad++; $display("[TB] FAIL cd_expired_flags got=%b%b want=00", running, game_en); end
            end
        end
        total++; if (ups != 1) begin bad++; $display("[TB] FAIL cd_up_count got=%0d want=1", ups); end
        step();
        total++; if (time_up !== 1'b0 || time_left !== 8'd0) begin bad++; $display("[TB] FAIL cd_hold got=%0d/%b want=0/0", time_left, time_up); end
    endtask

    task automatic test_expired_reload();
        $display("[TB] test_expired_reload");
        max_time = 8'd0;
        step(1'b1);
        total++; if (running !== 1'b1 || time_left !== 8'd3) begin bad++; $display("[TB] FAIL reload_latched got=%b/%0d want=1/3", running, time_left); end
        step(1'b0, 1'b0, 1'b1);
        total++; if (running !== 1'b0) begin bad++; $display("[TB] FAIL reload_abort got=%b want=0", running); end
    endtask

    task automatic test_pause();
        int moved;
        moved = 0;
        $display("[TB] test_pause");
        max_time = 8'd3;
        step(1'b1);
        for (int i = 1; i <= 15; i++) step(1'b0, (i == 15));
        total++; if (paused !== 1'b1 || running !== 1'b0 || game_en !== 1'b0) begin bad++; $display("[TB] FAIL pause_enter got=%b%b%b want=100", paused, running, game_en); end
        total++; if (time_left !== 8'd2) begin bad++; $display("[TB] FAIL pause_time got=%0d want=2", time_left); end
        repeat (50) begin
            step();
            if (time_left !== 8'd2 || paused !== 1'b1) moved++;
        end
        total++; if (moved != 0) begin bad++; $display("[TB] FAIL pause_frozen got=%0d want=0 bad cycles", moved); end
        step(1'b0, 1'b1);
        total++; if (running !== 1'b1 || paused !== 1'b0) begin bad++; $display("[TB] FAIL pause_resume got=%b%b want=10", running, paused); end
        repeat (4) step();
        total++; if (time_left !== 8'd2) begin bad++; $display("[TB] FAIL resume_early got=%0d want=2", time_left); end
        step();
        total++; if (time_left !== 8'd1) begin bad++; $display("[TB] FAIL resume_frac got=%0d want=1", time_left); end
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_zero_start();
        $display("[TB] test_zero_start");
        max_time = 8'd0;
        step(1'b1);
        total++; if (running !== 1'b0 || time_up !== 1'b0 || time_left !== 8'd0) begin bad++; $display("[TB] FAIL zero_ignored got=%b%b/%0d want=00/0", running, time_up, time_left); end
        repeat (3) step();
        total++; if (running !== 1'b0) begin bad++; $display("[TB] FAIL zero_stay got=%b want=0", running); end
        max_time = 8'd4;
        step(1'b1);
        total++; if (running !== 1'b1 || time_left !== 8'd4) begin bad++; $display("[TB] FAIL zero_then4 got=%b/%0d want=1/4", running, time_left); end
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_pause_at_expiry();
        $display("[TB] test_pause_at_expiry");
        max_time = 8'd2;
        step(1'b1);
        repeat (19) step();
        total++; if (time_left !== 8'd1) begin bad++; $display("[TB] FAIL pe_pre got=%0d want=1", time_left); end
        step(1'b0, 1'b1);
        total++; if (time_up !== 1'b1 || paused !== 1'b0 || time_left !== 8'd0) begin bad++; $display("[TB] FAIL pe_expire got=%b%b/%0d want=10/0", time_up, paused, time_left); end
        step();
        total++; if (time_up !== 1'b0) begin bad++; $display("[TB] FAIL pe_single got=%b want=0", time_up); end
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_warn();
        int hi;
        hi = 0;
        $display("[TB] test_warn");
        max_time = 8'd7;
        step(1'b1);
        for (int i = 1; i <= 70; i++) begin
            step();
            if (i >= 20 && i <= 29 && blink === 1'b1) hi++;
            if (i == 19) begin total++; if (warn !== 1'b0 || time_left !== 8'd6) begin bad++; $display("[TB] FAIL warn_pre got=%b/%0d want=0/6", warn, time_left); end end
            if (i == 20) begin total++; if (warn !== 1'b1 || time_left !== 8'd5) begin bad++; $display("[TB] FAIL warn_rise got=%b/%0d want=1/5", warn, time_left); end end
            if (i == 70) begin total++; if (warn !== 1'b0 || time_left !== 8'd0) begin bad++; $display("[TB] FAIL warn_zero got=%b/%0d want=0/0", warn, time_left); end end
        end
        total++; if (hi != 5) begin bad++; $display("[TB] FAIL blink_duty got=%0d want=5 high cycles", hi); end
        step(1'b0, 1'b0, 1'b1);
        total++; if (warn !== 1'b0 || blink !== 1'b0) begin bad++; $display("[TB] FAIL warn_idle got=%b%b want=00", warn, blink); end
    endtask

    task automatic test_abort();
        $display("[TB] test_abort");
        max_time = 8'd5;
        step(1'b1);
        repeat (12) step();
        step(1'b0, 1'b0, 1'b1);
        total++; if (running !== 1'b0 || paused !== 1'b0 || time_up !== 1'b0) begin bad++; $display("[TB] FAIL abort_idle got=%b%b%b want=000", running, paused, time_up); end
        step();
        total++; if (time_left !== 8'd5) begin bad++; $display("[TB] FAIL abort_follow got=%0d want=5", time_left); end
    endtask

    task automatic test_mid_reset();
        $display("[TB] test_mid_reset");
        max_time = 8'd6;
        step(1'b1);
        repeat (7) step();
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        total++; if (time_left !== 8'd0) begin bad++; $display("[TB] FAIL mr_time got=%0d want=0", time_left); end
        total++; if ({running, paused, game_en, time_up, warn, blink} !== 6'b0) begin bad++; $display("[TB] FAIL mr_flags got=%b want=000000", {running, paused, game_en, time_up, warn, blink}); end
        step();
        step();
        reset_n = 1'b1;
        step();
        total++; if (time_left !== 8'd6 || running !== 1'b0) begin bad++; $display("[TB] FAIL mr_release got=%0d/%b want=6/0", time_left, running); end
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        test_reset();
        test_countdown();
        test_expired_reload();
        test_pause();
        test_zero_start();
        test_pause_at_expiry();
        test_warn();
        test_abort();
        test_mid_reset();
        @(posedge clk);
        #2;
        total++; if (sb.size() != 0) begin bad++; $display("[TB] FAIL sb_drain got=%0d want=0 entries", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
